// File: rtl/riscv_pkg.sv
// Shared register-file types: architectural widths, register index type, address qualifier.
// Used by regfile_wb and reg_scoreboard.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned ISA_AW = 5;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef logic [REG_AW-1:0] reg_addr_t;

  // x0 and indices past the implemented file never store data or track a writer.
  function automatic logic addr_ok(input logic [ISA_AW-1:0] a, input int unsigned nreg);
    return (a != '0) && (32'(a) < nreg);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback, set wins.
// Set/clear take effect on the next rising clk; busy1/busy2 are combinational lookups.
module reg_scoreboard #(
  parameter int unsigned NREG = riscv_pkg::NREG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       busy1,
  output logic       busy2
);
  import riscv_pkg::*;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && addr_ok(set_rd, NREG)) set_vec[reg_addr_t'(set_rd)] = 1'b1;
    if (clr_en && addr_ok(clr_rd, NREG)) clr_vec[reg_addr_t'(clr_rd)] = 1'b1;
    // A new issue supersedes the retiring writer of the same register.
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy1 = addr_ok(rs1, NREG) ? busy_q[reg_addr_t'(rs1)] : 1'b0;
  assign busy2 = addr_ok(rs2, NREG) ? busy_q[reg_addr_t'(rs2)] : 1'b0;

endmodule

// File: rtl/regfile_wb.sv
// Two-read/one-write register file with writer scoreboard; writes land next edge, reads combinational.
// Optional same-cycle writeback forwarding under REGFILE_BYPASS_EN; no backpressure.
module regfile_wb #(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NREG = riscv_pkg::NREG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  input  logic [4:0]      wb_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            iss_en,
  input  logic [4:0]      iss_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            hazard
);
  import riscv_pkg::*;

  logic [XLEN-1:0] regs [NREG];
  logic            wr_ok;
  logic [XLEN-1:0] st1;
  logic [XLEN-1:0] st2;
  logic            sb_busy1;
  logic            sb_busy2;
  logic            hazard_q;

  assign wr_ok = wb_we && addr_ok(wb_rd, NREG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else if (wr_ok) begin
      regs[reg_addr_t'(wb_rd)] <= wb_data;
    end
  end

  assign st1 = addr_ok(rs1, NREG) ? regs[reg_addr_t'(rs1)] : '0;
  assign st2 = addr_ok(rs2, NREG) ? regs[reg_addr_t'(rs2)] : '0;

  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .set_en (iss_en),
    .set_rd (iss_rd),
    .clr_en (wb_we),
    .clr_rd (wb_rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy1  (sb_busy1),
    .busy2  (sb_busy2)
  );

`ifdef REGFILE_BYPASS_EN
  logic wb_hit1;
  logic wb_hit2;

  assign wb_hit1 = wr_ok && (wb_rd == rs1);
  assign wb_hit2 = wr_ok && (wb_rd == rs2);
  assign rd1 = wb_hit1 ? wb_data : st1;
  assign rd2 = wb_hit2 ? wb_data : st2;
  // The retiring result is forwarded, so the operand is ready unless a new writer issues now.
  assign busy1 = sb_busy1 && !(wb_hit1 && !(iss_en && (iss_rd == rs1)));
  assign busy2 = sb_busy2 && !(wb_hit2 && !(iss_en && (iss_rd == rs2)));
`else
  assign rd1   = st1;
  assign rd2   = st2;
  assign busy1 = sb_busy1;
  assign busy2 = sb_busy2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hazard_q <= 1'b0;
    end else begin
      hazard_q <= busy1 | busy2;
    end
  end

  assign hazard = hazard_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed steps plus random traffic against an array-based reference.
module tb_regfile_wb;

  localparam int unsigned W = 32;
  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         wb_we;
  logic [W-1:0] wb_data;
  logic [4:0]   wb_rd;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic         iss_en;
  logic [4:0]   iss_rd;
  logic         busy1;
  logic         busy2;
  logic         hazard;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mreg  [32];
  logic         mbusy [32];
  logic         mhaz;

  always #5 clk = ~clk;

  regfile_wb #(.XLEN(W), .NREG(N)) dut (
    .clk(clk), .reset(reset), .wb_we(wb_we), .wb_data(wb_data), .wb_rd(wb_rd),
    .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2), .iss_en(iss_en), .iss_rd(iss_rd),
    .busy1(busy1), .busy2(busy2), .hazard(hazard)
  );

  function automatic logic valid_a(input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < int'(N));
  endfunction

  function automatic logic [W-1:0] exp_rd(input logic [4:0] a);
    if (!valid_a(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == a) return wb_data;
`endif
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!valid_a(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_rd == a && !(iss_en && iss_rd == a)) return 1'b0;
`endif
    return mbusy[a];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".rd1"},    rd1,             exp_rd(rs1));
    chk({tag, ".rd2"},    rd2,             exp_rd(rs2));
    chk({tag, ".busy1"},  W'(busy1),       W'(exp_busy(rs1)));
    chk({tag, ".busy2"},  W'(busy2),       W'(exp_busy(rs2)));
    chk({tag, ".hazard"}, W'(hazard),      W'(mhaz));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
    mhaz = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [W-1:0] data,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic ie, input logic [4:0] ird);
    wb_we = we; wb_rd = rd; wb_data = data;
    rs1 = a1; rs2 = a2; iss_en = ie; iss_rd = ird;
    #1;
  endtask

  // Advance one edge; the reference retires the write, then applies the issue so set wins.
  task automatic tick();
    logic nh;
    nh = exp_busy(rs1) | exp_busy(rs2);
    @(posedge clk);
    if (reset) begin
      if (wb_we && valid_a(wb_rd)) begin
        mreg[wb_rd]  = wb_data;
        mbusy[wb_rd] = 1'b0;
      end
      if (iss_en && valid_a(iss_rd)) mbusy[iss_rd] = 1'b1;
      mhaz = nh;
    end
    #1;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b0;
    model_reset();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("rst.rd1", rd1, '0);
    chk("rst.hazard", W'(hazard), '0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Write x5, read it back; x0 write ignored.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0);
    check_outs("w5"); tick();
    drive(1'b1, 5'd0, 32'h00001234, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("x5_read", rd1, 32'hDEADBEEF);
    check_outs("w0"); tick();
    drive(1'b0, 5'd0, '0, 5'd5, 5'd0, 1'b0, 5'd0);
    chk("x0_read", rd2, '0);
    check_outs("r0"); tick();

    // Same-cycle write/read of x7.
    drive(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0, 1'b0, 5'd0);
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", rd1, 32'hA5A5A5A5);
`else
    chk("nobyp_same", rd1, 32'h11111111);
`endif
    check_outs("w7"); tick();
    drive(1'b0, 5'd0, '0, 5'd7, 5'd0, 1'b0, 5'd0);
    chk("x7_next", rd1, 32'hA5A5A5A5); tick();

    // Issue x3, observe busy then hazard, then retire.
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 5'd3); tick();
    drive(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("busy3", W'(busy1), W'(1)); tick();
    drive(1'b1, 5'd3, 32'h00000055, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("hazard3", W'(hazard), W'(1));
    check_outs("wb3"); tick();
    drive(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 5'd0);
    chk("busy3_clr", W'(busy1), '0);
    check_outs("r3"); tick();

    // Issue and retire x9 together: set wins, data lands.
    drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0, 1'b1, 5'd9);
    check_outs("iw9"); tick();
    drive(1'b0, 5'd0, '0, 5'd9, 5'd0, 1'b0, 5'd0);
    chk("busy9", W'(busy1), W'(1));
    chk("x9_data", rd1, 32'hCAFEF00D); tick();
    drive(1'b1, 5'd9, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0); tick();

    // Issue to x0 never marks busy.
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 5'd0); tick();
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("busy0", W'(busy1), '0); tick();
    chk("hazard0", W'(hazard), '0);

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), rnd_addr(), rnd_addr(),
            1'($urandom_range(0, 2) == 0), rnd_addr());
      check_outs("rand"); tick();
    end

    // Asynchronous reset mid-run with live traffic.
    drive(1'b1, 5'd5, 32'h5A5A0001, 5'd0, 5'd0, 1'b1, 5'd9); tick();
    drive(1'b1, 5'd6, 32'h0BADF00D, 5'd5, 5'd9, 1'b1, 5'd6);
    reset = 1'b0;
    #1;
    chk("arst.rd1", rd1, '0);
    chk("arst.rd2", rd2, '0);
    chk("arst.busy1", W'(busy1), '0);
    chk("arst.busy2", W'(busy2), '0);
    chk("arst.hazard", W'(hazard), '0);
    model_reset();
    @(posedge clk); #1;
    check_outs("arst_edge");
    #2 reset = 1'b1;
    #1 check_outs("rel");
    tick();
    drive(1'b0, 5'd0, '0, 5'd6, 5'd5, 1'b0, 5'd0);
    chk("rel.x6", rd1, 32'h0BADF00D);
    chk("rel.busy6", W'(busy1), W'(1));
    check_outs("post"); tick();

    for (int n = 0; n < 100; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), rnd_addr(), rnd_addr(),
            1'($urandom_range(0, 2) == 0), rnd_addr());
      check_outs("rand2"); tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
